// File: rtl/kronos_lsq_pkg.sv
// Shared types for the Kronos load/store queue: access size encoding and queue entry layout.
package kronos_lsq_pkg;

  typedef enum logic [1:0] {
    LSQ_BYTE = 2'd0,
    LSQ_HALF = 2'd1,
    LSQ_WORD = 2'd2
  } lsq_size_e;

  typedef struct packed {
    logic       store;
    lsq_size_e  size;
    logic       uns;
    logic [1:0] offset;
    logic [4:0] rd;
  } lsq_entry_t;

  localparam int LSQ_ENTRY_W = $bits(lsq_entry_t);

  // The illegal encoding 3 behaves as a word access.
  function automatic lsq_size_e lsq_size_decode(input logic [1:0] sz);
    case (sz)
      2'd0:    return LSQ_BYTE;
      2'd1:    return LSQ_HALF;
      default: return LSQ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/kronos_lsq_fifo.sv
// Synchronous FIFO holding outstanding bus transactions; also exposes every slot for hazard scans.
module kronos_lsq_fifo #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH*WIDTH-1:0] slots,
  output logic [DEPTH-1:0]       slot_vld
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slots[i*WIDTH +: WIDTH] = mem[i];
      slot_vld[i]             = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

endmodule

// File: rtl/kronos_lsq.sv
// Kronos load/store queue: pipelined in-order data bus with register write-back and pending mask.
// Optional fence handshake enabled by defining KRONOS_LSQ_FENCE_EN.
module kronos_lsq
  import kronos_lsq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              data_req,
  input  logic              data_gnt,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_wr_en,
  output logic [3:0]        data_mask,
  output logic [31:0]       data_wr_data,
  input  logic              data_rvld,
  input  logic [31:0]       data_rdata,
  output logic              regwr_en,
  output logic [4:0]        regwr_sel,
  output logic [31:0]       regwr_data,
  output logic [31:0]       pending_rd,
  output logic              busy
`ifdef KRONOS_LSQ_FENCE_EN
  ,
  input  logic              fence_vld,
  output logic              fence_rdy
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  lsq_size_e                    req_sz;
  lsq_entry_t                   push_ent;
  lsq_entry_t                   head_ent;
  lsq_entry_t                   slot_ent [DEPTH];
  logic [LSQ_ENTRY_W-1:0]       head_raw;
  logic [DEPTH*LSQ_ENTRY_W-1:0] slots;
  logic [DEPTH-1:0]             slot_vld;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;
  logic                         pop;
  logic                         issue_gate;

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input lsq_entry_t e);
    logic [31:0] sh;
    sh = rdata >> {e.offset, 3'b000};
    case (e.size)
      LSQ_BYTE: load_align = e.uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      LSQ_HALF: load_align = e.uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default:  load_align = sh;
    endcase
  endfunction

`ifdef KRONOS_LSQ_FENCE_EN
  logic fence_ack_p0;

  // The ack flag keeps the ready pulse to one cycle while the sequencer still holds the fence.
  assign issue_gate = fence_vld;
  assign fence_rdy  = fence_vld & ~fence_ack_p0 & (count == '0) & ~regwr_en;

  always_ff @(posedge clk) begin
    if (rst) fence_ack_p0 <= 1'b0;
    else     fence_ack_p0 <= fence_vld & (fence_ack_p0 | fence_rdy);
  end
`else
  assign issue_gate = 1'b0;
`endif

  // Issue stage (combinational)
  assign req_sz     = lsq_size_decode(req_size);
  assign data_req   = req_vld & ~full & ~issue_gate;
  assign req_rdy    = data_req & data_gnt;
  assign data_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign data_wr_en = data_req & req_store;

  always_comb begin
    data_mask    = 4'hF;
    data_wr_data = req_wdata;
    case (req_sz)
      LSQ_BYTE: begin
        data_mask    = 4'b0001 << req_addr[1:0];
        data_wr_data = {4{req_wdata[7:0]}};
      end
      LSQ_HALF: begin
        data_mask    = 4'b0011 << req_addr[1:0];
        data_wr_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign push_ent = '{store: req_store, size: req_sz, uns: req_unsigned,
                      offset: req_addr[1:0], rd: req_rd};
  assign head_ent = lsq_entry_t'(head_raw);
  assign pop      = data_rvld & ~empty;

  kronos_lsq_fifo #(
    .WIDTH (LSQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_rdy),
    .pop      (pop),
    .din      (push_ent),
    .head     (head_raw),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .slots    (slots),
    .slot_vld (slot_vld)
  );

  // Write-back stage p0: one cycle after the response
  always_ff @(posedge clk) begin
    if (rst) begin
      regwr_en   <= 1'b0;
      regwr_sel  <= '0;
      regwr_data <= '0;
    end else begin
      regwr_en <= pop & ~head_ent.store & (head_ent.rd != 5'd0);
      if (pop & ~head_ent.store) begin
        regwr_sel  <= head_ent.rd;
        regwr_data <= load_align(data_rdata, head_ent);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_ent[i] = lsq_entry_t'(slots[i*LSQ_ENTRY_W +: LSQ_ENTRY_W]);
    end
  end

  always_comb begin
    pending_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && !slot_ent[i].store) pending_rd[slot_ent[i].rd] = 1'b1;
    end
    if (regwr_en) pending_rd[regwr_sel] = 1'b1;
    pending_rd[0] = 1'b0;
  end

  assign busy = (count != '0) | regwr_en;

endmodule
